// File: rtl/cvxif_pkg.sv
// Shared CoreV-X-Interface types and widths, plus the core-side ID table entry.
package cvxif_pkg;

  localparam int unsigned X_ID_WIDTH  = 4;
  localparam int unsigned X_NUM_RS    = 2;
  localparam int unsigned X_RFR_WIDTH = 32;
  localparam int unsigned X_RFW_WIDTH = 32;
  localparam int unsigned X_MEM_WIDTH = 32;

  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;

  typedef struct packed {
    logic [15:0]           instr;
    priv_lvl_e             mode;
    logic [X_ID_WIDTH-1:0] id;
  } x_compressed_req_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        accept;
  } x_compressed_resp_t;

  typedef struct packed {
    logic [31:0]                             instr;
    priv_lvl_e                               mode;
    logic [X_ID_WIDTH-1:0]                   id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]    rs;
    logic [X_NUM_RS-1:0]                     rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  x_commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [31:0]            addr;
    priv_lvl_e              mode;
    logic                   we;
    logic [1:0]             size;
    logic [X_MEM_WIDTH-1:0] wdata;
    logic                   last;
    logic                   spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
    logic       dbg;
  } x_mem_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_MEM_WIDTH-1:0] rdata;
    logic                   err;
    logic                   dbg;
  } x_mem_result_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
    logic [5:0]             exccode;
    logic                   err;
    logic                   dbg;
  } x_result_t;

  typedef struct packed {
    logic              x_compressed_valid;
    x_compressed_req_t x_compressed_req;
    logic              x_issue_valid;
    x_issue_req_t      x_issue_req;
    logic              x_commit_valid;
    x_commit_t         x_commit;
    logic              x_mem_ready;
    x_mem_resp_t       x_mem_resp;
    logic              x_mem_result_valid;
    x_mem_result_t     x_mem_result;
    logic              x_result_ready;
  } cvxif_req_t;

  typedef struct packed {
    logic               x_compressed_ready;
    x_compressed_resp_t x_compressed_resp;
    logic               x_issue_ready;
    x_issue_resp_t      x_issue_resp;
    logic               x_mem_valid;
    x_mem_req_t         x_mem_req;
    logic               x_result_valid;
    x_result_t          x_result;
  } cvxif_resp_t;

  // One in-flight offloaded instruction as tracked by the core.
  typedef struct packed {
    logic       valid;
    logic       committed;
    logic       writeback;
    logic [4:0] rd;
  } x_id_entry_t;

endpackage

// File: rtl/cvxif_id_table.sv
// Transaction ID table: lowest-free allocation, commit marking, free on kill or result.
module cvxif_id_table
  import cvxif_pkg::*;
#(
  parameter int unsigned NrOutstanding = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // allocation (issue handshake with accept)
  input  logic                  alloc_i,
  input  logic                  alloc_wb_i,
  input  logic [4:0]            alloc_rd_i,
  output logic [X_ID_WIDTH-1:0] alloc_id_o,
  output logic                  full_o,
  // forwarded commit/kill
  input  logic                  commit_i,
  input  logic                  kill_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  output logic                  commit_id_valid_o,
  // result lookup and free
  input  logic [X_ID_WIDTH-1:0] res_id_i,
  input  logic                  res_free_i,
  output x_id_entry_t           res_entry_o
);

  localparam int unsigned IdxW = (NrOutstanding > 1) ? $clog2(NrOutstanding) : 1;

  x_id_entry_t [NrOutstanding-1:0] table_q, table_d;
  logic [IdxW-1:0] alloc_idx;
  logic [IdxW-1:0] cidx, ridx;
  logic            commit_in_range, res_in_range;

  assign cidx            = commit_id_i[IdxW-1:0];
  assign ridx            = res_id_i[IdxW-1:0];
  assign commit_in_range = 32'(commit_id_i) < NrOutstanding;
  assign res_in_range    = 32'(res_id_i) < NrOutstanding;

  assign commit_id_valid_o = commit_in_range && table_q[cidx].valid;
  assign res_entry_o       = res_in_range ? table_q[ridx] : '0;
  assign alloc_id_o        = X_ID_WIDTH'(alloc_idx);

  // Lowest-index free entry from the mask registered at the start of the cycle.
  always_comb begin
    alloc_idx = '0;
    full_o    = 1'b1;
    for (int i = int'(NrOutstanding) - 1; i >= 0; i--) begin
      if (!table_q[i].valid) begin
        alloc_idx = IdxW'(i);
        full_o    = 1'b0;
      end
    end
  end

  // Next table state: commit-mark, kill-free, result-free, then allocate.
  always_comb begin
    // NOTE: start from the held value so every path assigns table_d and no latch is inferred.
    table_d = table_q;
    if (commit_i && commit_id_valid_o) begin
      if (kill_i) table_d[cidx] = '0;
      else        table_d[cidx].committed = 1'b1;
    end
    if (res_free_i && res_in_range) table_d[ridx] = '0;
    if (alloc_i && !full_o) begin
      table_d[alloc_idx].valid     = 1'b1;
      table_d[alloc_idx].committed = 1'b0;
      table_d[alloc_idx].writeback = alloc_wb_i;
      table_d[alloc_idx].rd        = alloc_rd_i;
    end
  end

  // Table state register.
  always_ff @(posedge clk_i) begin
    // NOTE: the table is a handful of flops, not a RAM, so it is reset in full; valid bits must clear.
    if (!rst_ni) table_q <= '0;
    // NOTE: non-blocking for all clocked state so every reader sees the pre-edge value.
    else         table_q <= table_d;
  end

endmodule

// File: rtl/cvxif_offload_ctrl.sv
// Core-side X-IF initiator: issue handshake, ID tracking, commit forwarding, one-entry write-back.
module cvxif_offload_ctrl
  import cvxif_pkg::*;
#(
  parameter int unsigned NrOutstanding = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 instr_valid_i,
  output logic                                 instr_ready_o,
  input  logic [31:0]                          instr_i,
  input  logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs_i,
  input  logic [X_NUM_RS-1:0]                  rs_valid_i,
  output logic [X_ID_WIDTH-1:0]                issue_id_o,
  output logic                                 issue_accept_o,
  output logic                                 issue_wb_o,
  input  logic                                 commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]                commit_id_i,
  input  logic                                 commit_kill_i,
  output logic                                 wb_valid_o,
  input  logic                                 wb_ready_i,
  output logic [X_ID_WIDTH-1:0]                wb_id_o,
  output logic [4:0]                           wb_rd_o,
  output logic [X_RFW_WIDTH-1:0]               wb_data_o,
  output logic                                 wb_we_o,
  output logic                                 wb_exc_o,
  output logic [5:0]                           wb_exccode_o,
  output logic                                 protocol_err_o,
  output cvxif_req_t                           cvxif_req_o,
  input  cvxif_resp_t                          cvxif_resp_i
);

  logic                  full;
  logic [X_ID_WIDTH-1:0] alloc_id;
  logic                  issue_valid, issue_hs, alloc;
  logic                  commit_valid_q;
  x_commit_t             commit_q;
  logic                  commit_id_valid;
  x_id_entry_t           res_entry;
  logic                  kill_now, wb_space, result_ready, res_fwd, res_err;
  logic                  wb_valid_q;

  // Issue side.
  assign issue_valid    = instr_valid_i & ~full;
  assign issue_hs       = issue_valid & cvxif_resp_i.x_issue_ready;
  assign alloc          = issue_hs & cvxif_resp_i.x_issue_resp.accept;
  assign instr_ready_o  = issue_hs;
  assign issue_id_o     = issue_hs ? alloc_id : '0;
  assign issue_accept_o = alloc;
  assign issue_wb_o     = alloc & cvxif_resp_i.x_issue_resp.writeback;

  // Result side: a kill forwarded this cycle for the same live ID wins over the result.
  assign kill_now     = commit_valid_q & commit_q.x_commit_kill & res_entry.valid
                      & (commit_q.id == cvxif_resp_i.x_result.id);
  assign wb_space     = ~wb_valid_q | wb_ready_i;
  assign result_ready = cvxif_resp_i.x_result_valid
                      & (~res_entry.valid | kill_now | (res_entry.committed & wb_space));
  assign res_fwd      = result_ready & res_entry.valid & ~kill_now;
  assign res_err      = result_ready & ~res_entry.valid;

  cvxif_id_table #(
    .NrOutstanding (NrOutstanding)
  ) u_id_table (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .alloc_i           (alloc),
    .alloc_wb_i        (cvxif_resp_i.x_issue_resp.writeback),
    .alloc_rd_i        (instr_i[11:7]),
    .alloc_id_o        (alloc_id),
    .full_o            (full),
    .commit_i          (commit_valid_q),
    .kill_i            (commit_q.x_commit_kill),
    .commit_id_i       (commit_q.id),
    .commit_id_valid_o (commit_id_valid),
    .res_id_i          (cvxif_resp_i.x_result.id),
    .res_free_i        (res_fwd),
    .res_entry_o       (res_entry)
  );

  // Delay the core's commit decision by one cycle onto the X-IF commit channel.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      commit_valid_q <= 1'b0;
      commit_q       <= '0;
    end else begin
      commit_valid_q         <= commit_valid_i;
      commit_q.id            <= commit_id_i;
      commit_q.x_commit_kill <= commit_kill_i;
    end
  end

  // One-entry write-back register: load on forwarded result, drain on wb_ready_i.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wb_valid_q   <= 1'b0;
      wb_id_o      <= '0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      wb_we_o      <= 1'b0;
      wb_exc_o     <= 1'b0;
      wb_exccode_o <= '0;
    end else if (res_fwd) begin
      wb_valid_q   <= 1'b1;
      wb_id_o      <= cvxif_resp_i.x_result.id;
      wb_rd_o      <= res_entry.rd;
      wb_data_o    <= cvxif_resp_i.x_result.data;
      wb_we_o      <= cvxif_resp_i.x_result.we & res_entry.writeback;
      wb_exc_o     <= cvxif_resp_i.x_result.exc;
      wb_exccode_o <= cvxif_resp_i.x_result.exccode;
    end else if (wb_ready_i) begin
      wb_valid_q   <= 1'b0;
    end
  end

  assign wb_valid_o = wb_valid_q;

  // Sticky protocol error: commit or result naming an ID that is not in flight.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                                                    protocol_err_o <= 1'b0;
    else if ((commit_valid_q & ~commit_id_valid) | res_err)         protocol_err_o <= 1'b1;
  end

  // X-IF request bundle; compressed and memory channels stay tied off.
  always_comb begin
    cvxif_req_o                      = '0;
    cvxif_req_o.x_issue_valid        = issue_valid;
    cvxif_req_o.x_issue_req.instr    = instr_i;
    cvxif_req_o.x_issue_req.mode     = PRIV_LVL_M;
    cvxif_req_o.x_issue_req.id       = alloc_id;
    cvxif_req_o.x_issue_req.rs       = rs_i;
    cvxif_req_o.x_issue_req.rs_valid = rs_valid_i;
    cvxif_req_o.x_commit_valid       = commit_valid_q;
    cvxif_req_o.x_commit             = commit_q;
    cvxif_req_o.x_result_ready       = result_ready;
  end

  // Response fields this initiator has no use for.
  logic unused_resp;
  assign unused_resp = ^{cvxif_resp_i.x_compressed_ready, cvxif_resp_i.x_compressed_resp,
                         cvxif_resp_i.x_mem_valid, cvxif_resp_i.x_mem_req,
                         cvxif_resp_i.x_issue_resp.dualwrite, cvxif_resp_i.x_issue_resp.dualread,
                         cvxif_resp_i.x_issue_resp.loadstore, cvxif_resp_i.x_issue_resp.exc,
                         cvxif_resp_i.x_result.rd, cvxif_resp_i.x_result.err,
                         cvxif_resp_i.x_result.dbg};

endmodule

// File: tb/tb_cvxif_offload_ctrl.sv
// Directed bench for cvxif_offload_ctrl with hand-computed expectations.
module tb_cvxif_offload_ctrl;
  import cvxif_pkg::*;

  logic                                 clk_i = 1'b0;
  logic                                 rst_ni;
  logic                                 instr_valid_i;
  logic                                 instr_ready_o;
  logic [31:0]                          instr_i;
  logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs_i;
  logic [X_NUM_RS-1:0]                  rs_valid_i;
  logic [X_ID_WIDTH-1:0]                issue_id_o;
  logic                                 issue_accept_o;
  logic                                 issue_wb_o;
  logic                                 commit_valid_i;
  logic [X_ID_WIDTH-1:0]                commit_id_i;
  logic                                 commit_kill_i;
  logic                                 wb_valid_o;
  logic                                 wb_ready_i;
  logic [X_ID_WIDTH-1:0]                wb_id_o;
  logic [4:0]                           wb_rd_o;
  logic [X_RFW_WIDTH-1:0]               wb_data_o;
  logic                                 wb_we_o;
  logic                                 wb_exc_o;
  logic [5:0]                           wb_exccode_o;
  logic                                 protocol_err_o;
  cvxif_req_t                           req;
  cvxif_resp_t                          resp;

  int n_checks = 0;
  int n_err    = 0;

  cvxif_offload_ctrl #(.NrOutstanding(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .instr_valid_i  (instr_valid_i),
    .instr_ready_o  (instr_ready_o),
    .instr_i        (instr_i),
    .rs_i           (rs_i),
    .rs_valid_i     (rs_valid_i),
    .issue_id_o     (issue_id_o),
    .issue_accept_o (issue_accept_o),
    .issue_wb_o     (issue_wb_o),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .wb_valid_o     (wb_valid_o),
    .wb_ready_i     (wb_ready_i),
    .wb_id_o        (wb_id_o),
    .wb_rd_o        (wb_rd_o),
    .wb_data_o      (wb_data_o),
    .wb_we_o        (wb_we_o),
    .wb_exc_o       (wb_exc_o),
    .wb_exccode_o   (wb_exccode_o),
    .protocol_err_o (protocol_err_o),
    .cvxif_req_o    (req),
    .cvxif_resp_i   (resp)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; instr_valid_i = 1'b0; instr_i = '0; rs_i = '0; rs_valid_i = '0;
    commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0; wb_ready_i = 1'b0;
    resp = '0;
    tick(); tick();

    // ---- reset state ----
    check("rst_instr_ready",   instr_ready_o, 0);
    check("rst_issue_valid",   req.x_issue_valid, 0);
    check("rst_commit_valid",  req.x_commit_valid, 0);
    check("rst_result_ready",  req.x_result_ready, 0);
    check("rst_wb_valid",      wb_valid_o, 0);
    check("rst_wb_data",       wb_data_o, 0);
    check("rst_protocol_err",  protocol_err_o, 0);
    check("rst_compr_valid",   req.x_compressed_valid, 0);
    check("rst_mem_ready",     req.x_mem_ready, 0);
    check("rst_mem_res_valid", req.x_mem_result_valid, 0);
    rst_ni = 1'b1;
    tick();

    // ---- accepted issue, commit, result ----
    instr_valid_i = 1'b1; instr_i = 32'h0021_80AB;
    rs_i[0] = 32'd5; rs_i[1] = 32'd7; rs_valid_i = 2'b11;
    resp.x_issue_ready = 1'b1; resp.x_issue_resp.accept = 1'b1; resp.x_issue_resp.writeback = 1'b1;
    #1;
    check("t1_x_issue_valid", req.x_issue_valid, 1);
    check("t1_x_issue_id",    req.x_issue_req.id, 0);
    check("t1_x_issue_instr", req.x_issue_req.instr, 32'h0021_80AB);
    check("t1_x_issue_rs1",   req.x_issue_req.rs[1], 7);
    check("t1_x_issue_mode",  req.x_issue_req.mode, 2'b11);
    check("t1_instr_ready",   instr_ready_o, 1);
    check("t1_issue_id",      issue_id_o, 0);
    check("t1_issue_accept",  issue_accept_o, 1);
    check("t1_issue_wb",      issue_wb_o, 1);
    tick();
    instr_valid_i = 1'b0;
    commit_valid_i = 1'b1; commit_id_i = 4'd0; commit_kill_i = 1'b0;
    #1;
    check("t1_commit_not_yet", req.x_commit_valid, 0);
    tick();
    commit_valid_i = 1'b0;
    #1;
    check("t1_x_commit_valid", req.x_commit_valid, 1);
    check("t1_x_commit_id",    req.x_commit.id, 0);
    check("t1_x_commit_kill",  req.x_commit.x_commit_kill, 0);
    tick();
    check("t1_x_commit_pulse", req.x_commit_valid, 0);
    resp.x_result_valid = 1'b1; resp.x_result.id = 4'd0; resp.x_result.data = 32'd12;
    resp.x_result.we = 1'b1; wb_ready_i = 1'b1;
    #1;
    check("t1_result_ready", req.x_result_ready, 1);
    tick();
    resp.x_result_valid = 1'b0;
    check("t1_wb_valid", wb_valid_o, 1);
    check("t1_wb_id",    wb_id_o, 0);
    check("t1_wb_rd",    wb_rd_o, 1);
    check("t1_wb_data",  wb_data_o, 12);
    check("t1_wb_we",    wb_we_o, 1);
    check("t1_wb_exc",   wb_exc_o, 0);
    tick();
    check("t1_wb_drained", wb_valid_o, 0);

    // ---- rejected issue, then fill the table ----
    instr_valid_i = 1'b1; instr_i = 32'h0000_052B;   // rd 10
    resp.x_issue_resp.accept = 1'b0; resp.x_issue_resp.writeback = 1'b0;
    #1;
    check("t2_rej_ready",  instr_ready_o, 1);
    check("t2_rej_accept", issue_accept_o, 0);
    check("t2_rej_id",     issue_id_o, 0);
    tick();
    resp.x_issue_resp.accept = 1'b1; resp.x_issue_resp.writeback = 1'b1;
    #1;
    check("t3_fill_id0", issue_id_o, 0);
    check("t3_fill_acc", issue_accept_o, 1);
    tick();
    instr_i = 32'h0000_05AB;                          // rd 11
    #1;
    check("t3_fill_id1", issue_id_o, 1);
    tick();
    instr_i = 32'h0000_062B;                          // rd 12
    #1;
    check("t3_fill_id2", issue_id_o, 2);
    tick();
    instr_i = 32'h0000_06AB;                          // rd 13, no write-back
    resp.x_issue_resp.writeback = 1'b0;
    #1;
    check("t3_fill_id3", issue_id_o, 3);
    check("t3_fill_wb3", issue_wb_o, 0);
    tick();
    instr_i = 32'h0000_072B;                          // rd 14
    resp.x_issue_resp.writeback = 1'b1;
    #1;
    check("t3_full_ready", instr_ready_o, 0);
    check("t3_full_valid", req.x_issue_valid, 0);

    // kill id 2; the slot comes back the cycle after x_commit
    commit_valid_i = 1'b1; commit_id_i = 4'd2; commit_kill_i = 1'b1;
    tick();
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    #1;
    check("t3_kill_fwd",     req.x_commit_valid, 1);
    check("t3_kill_flag",    req.x_commit.x_commit_kill, 1);
    check("t3_kill_id",      req.x_commit.id, 2);
    check("t3_kill_still_full", instr_ready_o, 0);
    tick();
    check("t3_realloc_ready", instr_ready_o, 1);
    check("t3_realloc_id",    issue_id_o, 2);
    tick();
    instr_valid_i = 1'b0;

    // ---- result before commit (id 1) ----
    wb_ready_i = 1'b0;
    resp.x_result_valid = 1'b1; resp.x_result.id = 4'd1; resp.x_result.data = 32'h11; resp.x_result.we = 1'b1;
    #1;
    check("t4_uncommitted_stall", req.x_result_ready, 0);
    commit_valid_i = 1'b1; commit_id_i = 4'd1;
    tick();
    commit_valid_i = 1'b0;
    #1;
    check("t4_commit_fwd",       req.x_commit_valid, 1);
    check("t4_stall_on_fwd_cyc", req.x_result_ready, 0);
    tick();
    check("t4_ready_after", req.x_result_ready, 1);
    tick();
    resp.x_result_valid = 1'b0;
    check("t4_wb_valid", wb_valid_o, 1);
    check("t4_wb_id",    wb_id_o, 1);
    check("t4_wb_rd",    wb_rd_o, 11);
    check("t4_wb_data",  wb_data_o, 32'h11);

    // ---- backpressure with out-of-order results (id 3 then id 0) ----
    commit_valid_i = 1'b1; commit_id_i = 4'd0;
    tick();
    commit_id_i = 4'd3;
    tick();
    commit_valid_i = 1'b0;
    tick();
    check("t5_hold0_data", wb_data_o, 32'h11);
    resp.x_result_valid = 1'b1; resp.x_result.id = 4'd3; resp.x_result.data = 32'h33; resp.x_result.we = 1'b1;
    #1;
    check("t5_stall0", req.x_result_ready, 0);
    tick();
    check("t5_stall1",      req.x_result_ready, 0);
    check("t5_hold1_id",    wb_id_o, 1);
    check("t5_hold1_data",  wb_data_o, 32'h11);
    tick();
    check("t5_stall2",      req.x_result_ready, 0);
    check("t5_hold2_valid", wb_valid_o, 1);
    wb_ready_i = 1'b1;
    #1;
    check("t5_release", req.x_result_ready, 1);
    tick();
    resp.x_result.id = 4'd0; resp.x_result.data = 32'h44;
    check("t5_second_valid", wb_valid_o, 1);
    check("t5_second_id",    wb_id_o, 3);
    check("t5_second_data",  wb_data_o, 32'h33);
    check("t5_second_rd",    wb_rd_o, 13);
    check("t5_second_we",    wb_we_o, 0);
    #1;
    check("t5_b2b_ready", req.x_result_ready, 1);
    tick();
    resp.x_result_valid = 1'b0;
    check("t5_third_id",   wb_id_o, 0);
    check("t5_third_data", wb_data_o, 32'h44);
    check("t5_third_rd",   wb_rd_o, 10);
    check("t5_third_we",   wb_we_o, 1);
    tick();
    check("t5_empty", wb_valid_o, 0);

    // ---- kill and result for id 2 in the same cycle ----
    commit_valid_i = 1'b1; commit_id_i = 4'd2; commit_kill_i = 1'b1;
    tick();
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    resp.x_result_valid = 1'b1; resp.x_result.id = 4'd2; resp.x_result.data = 32'h55;
    #1;
    check("t6_kill_drain", req.x_result_ready, 1);
    tick();
    resp.x_result_valid = 1'b0;
    check("t6_not_fwd", wb_valid_o, 0);
    check("t6_no_err",  protocol_err_o, 0);

    // ---- result for unissued id 3 ----
    resp.x_result_valid = 1'b1; resp.x_result.id = 4'd3; resp.x_result.data = 32'h66;
    #1;
    check("t7_drain_ready", req.x_result_ready, 1);
    tick();
    resp.x_result_valid = 1'b0;
    check("t7_err_set",  protocol_err_o, 1);
    check("t7_not_fwd",  wb_valid_o, 0);
    tick(); tick();
    check("t7_err_sticky", protocol_err_o, 1);

    // ---- reset mid-transaction ----
    instr_valid_i = 1'b1; instr_i = 32'h0000_052B;
    tick(); tick();
    instr_valid_i = 1'b0;
    commit_valid_i = 1'b1; commit_id_i = 4'd0;
    tick();
    rst_ni = 1'b0; commit_valid_i = 1'b0;
    tick();
    check("t8_rst_commit",  req.x_commit_valid, 0);
    check("t8_rst_err",     protocol_err_o, 0);
    check("t8_rst_wb",      wb_valid_o, 0);
    check("t8_rst_ready",   instr_ready_o, 0);
    check("t8_rst_res_rdy", req.x_result_ready, 0);
    rst_ni = 1'b1; instr_valid_i = 1'b1;
    #1;
    check("t8_table_empty_rdy", instr_ready_o, 1);
    check("t8_table_empty_id",  issue_id_o, 0);
    tick();
    instr_valid_i = 1'b0;

    // ---- commit to an ID that is not in flight ----
    commit_valid_i = 1'b1; commit_id_i = 4'd3; commit_kill_i = 1'b0;
    tick();
    commit_valid_i = 1'b0;
    #1;
    check("t9_bad_commit_fwd", req.x_commit_valid, 1);
    check("t9_bad_commit_id",  req.x_commit.id, 3);
    check("t9_err_not_yet",    protocol_err_o, 0);
    tick();
    check("t9_err_set", protocol_err_o, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
